// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer.
// Holds the geometry constants (entry count, tag/index/count widths), the data-path
// widths, the entry-type codes, the "no dependency" tag value and the per-entry record.
// Tags are slot index + 1, so ROB_SIZE must stay <= 31 for tags to fit in TAG_W bits.
package reorder_buffer_pkg;

  localparam int unsigned ROB_SIZE = 16;
  localparam int unsigned TAG_W    = 5;
  localparam int unsigned IDX_W    = $clog2(ROB_SIZE);
  localparam int unsigned CNT_W    = $clog2(ROB_SIZE + 1);
  localparam int unsigned REG_W    = 5;
  localparam int unsigned DATA_W   = 32;

  // Tag value meaning "operand has no producer in flight".
  localparam logic [TAG_W-1:0] NO_DEP = '0;

  typedef enum logic [1:0] {
    TypeRegWrite = 2'd0,
    TypeBranch   = 2'd1,
    TypeStore    = 2'd2
  } rob_type_e;

  typedef struct packed {
    logic              busy;
    logic              ready;
    rob_type_e         typ;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] value;
    logic              mispredict;
    logic [DATA_W-1:0] target_pc;
  } rob_entry_t;

  function automatic logic [TAG_W-1:0] idx_to_tag(input logic [IDX_W-1:0] idx);
    return TAG_W'(idx) + TAG_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] tag_to_idx(input logic [TAG_W-1:0] tag);
    return IDX_W'(tag - TAG_W'(1));
  endfunction

  // True when the tag names a real slot (not NO_DEP, not beyond the last entry).
  function automatic logic tag_in_range(input logic [TAG_W-1:0] tag);
    return (tag != NO_DEP) && (tag <= TAG_W'(ROB_SIZE));
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Bus bundle between the reorder buffer and the rest of the core.
// Groups the dispatch request/tag-grant, the operand-readiness queries, the CDB
// broadcast, the register-file commit bus, the store-commit strobe and the rollback.
//   slave  : the reorder buffer side (consumes dispatch/query/CDB, drives commit/rollback)
//   master : the surrounding core side (drives dispatch/query/CDB, observes the rest)
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  // Dispatch
  logic              disp_valid;
  logic [1:0]        disp_type;
  logic [REG_W-1:0]  disp_rd;
  logic [DATA_W-1:0] disp_pc;
  logic [TAG_W-1:0]  alloc_tag;
  logic              full;

  // Operand readiness queries
  logic [TAG_W-1:0]  query_tag1;
  logic [TAG_W-1:0]  query_tag2;
  logic              query_ready1;
  logic              query_ready2;
  logic [DATA_W-1:0] query_value1;
  logic [DATA_W-1:0] query_value2;

  // Common data bus
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;
  logic              cdb_mispredict;
  logic [DATA_W-1:0] cdb_target_pc;

  // Retirement
  logic              result_valid_to_reg;
  logic [REG_W-1:0]  reg_id_to_reg;
  logic [TAG_W-1:0]  alias_to_reg;
  logic [DATA_W-1:0] result_to_reg;
  logic              store_commit;
  logic              rollback;
  logic [DATA_W-1:0] rollback_pc;

  modport slave (
    input  disp_valid, disp_type, disp_rd, disp_pc,
    output alloc_tag, full,
    input  query_tag1, query_tag2,
    output query_ready1, query_ready2, query_value1, query_value2,
    input  cdb_valid, cdb_tag, cdb_value, cdb_mispredict, cdb_target_pc,
    output result_valid_to_reg, reg_id_to_reg, alias_to_reg, result_to_reg,
    output store_commit, rollback, rollback_pc
  );

  modport master (
    output disp_valid, disp_type, disp_rd, disp_pc,
    input  alloc_tag, full,
    output query_tag1, query_tag2,
    input  query_ready1, query_ready2, query_value1, query_value2,
    output cdb_valid, cdb_tag, cdb_value, cdb_mispredict, cdb_target_pc,
    input  result_valid_to_reg, reg_id_to_reg, alias_to_reg, result_to_reg,
    input  store_commit, rollback, rollback_pc
  );

endinterface

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order retirement unit of the Tomasulo core.
// Allocates a tag (slot index + 1) per dispatched instruction, captures CDB results,
// retires the head entry when it is ready, and flushes everything on a mispredicted
// branch reaching the head.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   rdy  - global enable; when low all state is frozen and no strobe is issued
//   bus  - reorder_buffer_if.slave: dispatch, queries, CDB, commit bus, rollback
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input logic             clk,
  input logic             rst,
  input logic             rdy,
  reorder_buffer_if.slave bus
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(ROB_SIZE - 1);
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(ROB_SIZE);

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] ptr);
    return (ptr == LastIdx) ? '0 : ptr + IDX_W'(1);
  endfunction

  rob_entry_t        entries_q [ROB_SIZE];
  rob_entry_t        entries_d [ROB_SIZE];
  logic [IDX_W-1:0]  head_q, head_d;
  logic [IDX_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              result_valid_q, result_valid_d;
  logic [REG_W-1:0]  reg_id_q, reg_id_d;
  logic [TAG_W-1:0]  alias_q, alias_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              store_commit_q, store_commit_d;
  logic              rollback_q, rollback_d;
  logic [DATA_W-1:0] rollback_pc_q, rollback_pc_d;

  rob_entry_t        head_e;
  logic              full_w;
  logic              do_commit;
  logic              do_flush;
  logic              accept_in;
  logic              do_alloc;
  logic              do_cdb;
  logic [IDX_W-1:0]  cdb_idx;
  logic [IDX_W-1:0]  q1_idx;
  logic [IDX_W-1:0]  q2_idx;

  // The fetch PC is carried on the dispatch bus but retirement never needs it.
  logic unused_disp_pc;
  assign unused_disp_pc = ^bus.disp_pc;

  assign full_w        = (count_q == FullCnt);
  assign bus.full      = full_w;
  assign bus.alloc_tag = idx_to_tag(tail_q);

  assign bus.result_valid_to_reg = result_valid_q;
  assign bus.reg_id_to_reg       = reg_id_q;
  assign bus.alias_to_reg        = alias_q;
  assign bus.result_to_reg       = result_q;
  assign bus.store_commit        = store_commit_q;
  assign bus.rollback            = rollback_q;
  assign bus.rollback_pc         = rollback_pc_q;

  // Operand lookups see registered state only; same-cycle CDB data is not forwarded.
  assign q1_idx = tag_to_idx(bus.query_tag1);
  assign q2_idx = tag_to_idx(bus.query_tag2);

  always_comb begin
    bus.query_ready1 = 1'b0;
    bus.query_value1 = '0;
    if (tag_in_range(bus.query_tag1) && entries_q[q1_idx].busy && entries_q[q1_idx].ready) begin
      bus.query_ready1 = 1'b1;
      bus.query_value1 = entries_q[q1_idx].value;
    end
  end

  always_comb begin
    bus.query_ready2 = 1'b0;
    bus.query_value2 = '0;
    if (tag_in_range(bus.query_tag2) && entries_q[q2_idx].busy && entries_q[q2_idx].ready) begin
      bus.query_ready2 = 1'b1;
      bus.query_value2 = entries_q[q2_idx].value;
    end
  end

  // Next-state: CDB writeback, head retirement, tail allocation, and flush override.
  always_comb begin
    entries_d      = entries_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    result_valid_d = 1'b0;
    store_commit_d = 1'b0;
    rollback_d     = 1'b0;
    reg_id_d       = reg_id_q;
    alias_d        = alias_q;
    result_d       = result_q;
    rollback_pc_d  = rollback_pc_q;

    head_e    = entries_q[head_q];
    cdb_idx   = tag_to_idx(bus.cdb_tag);
    do_commit = rdy && head_e.busy && head_e.ready;
    do_flush  = do_commit && (head_e.typ == TypeBranch) && head_e.mispredict;
    // Inputs are discarded at a flushing edge and while the rollback strobe is out.
    accept_in = rdy && !rollback_q && !do_flush;
    do_alloc  = accept_in && bus.disp_valid && !full_w;
    do_cdb    = accept_in && bus.cdb_valid && tag_in_range(bus.cdb_tag) &&
                entries_q[cdb_idx].busy;

    if (do_cdb) begin
      entries_d[cdb_idx].ready      = 1'b1;
      entries_d[cdb_idx].value      = bus.cdb_value;
      entries_d[cdb_idx].mispredict = bus.cdb_mispredict;
      entries_d[cdb_idx].target_pc  = bus.cdb_target_pc;
    end

    if (do_commit) begin
      entries_d[head_q].busy = 1'b0;
      head_d                 = ptr_inc(head_q);
      case (head_e.typ)
        TypeRegWrite: begin
          // Writes to x0 retire silently.
          if (head_e.rd != '0) begin
            result_valid_d = 1'b1;
            reg_id_d       = head_e.rd;
            alias_d        = idx_to_tag(head_q);
            result_d       = head_e.value;
          end
        end
        TypeStore: store_commit_d = 1'b1;
        TypeBranch: begin
          if (head_e.mispredict) begin
            rollback_d    = 1'b1;
            rollback_pc_d = head_e.target_pc;
          end
        end
        default: ;
      endcase
    end

    // Allocation checks full against the pre-edge count, so it never lands on the head
    // slot being retired in the same cycle.
    if (do_alloc) begin
      entries_d[tail_q] = '{
        busy:       1'b1,
        ready:      1'b0,
        typ:        rob_type_e'(bus.disp_type),
        rd:         bus.disp_rd,
        value:      '0,
        mispredict: 1'b0,
        target_pc:  '0
      };
      tail_d = ptr_inc(tail_q);
    end

    if (do_alloc && !do_commit) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_alloc && do_commit) begin
      count_d = count_q - CNT_W'(1);
    end

    if (do_flush) begin
      for (int unsigned i = 0; i < ROB_SIZE; i++) begin
        entries_d[i].busy = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ROB_SIZE; i++) begin
        entries_q[i] <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      result_valid_q <= 1'b0;
      reg_id_q       <= '0;
      alias_q        <= '0;
      result_q       <= '0;
      store_commit_q <= 1'b0;
      rollback_q     <= 1'b0;
      rollback_pc_q  <= '0;
    end else begin
      entries_q      <= entries_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      result_valid_q <= result_valid_d;
      reg_id_q       <= reg_id_d;
      alias_q        <= alias_d;
      result_q       <= result_d;
      store_commit_q <= store_commit_d;
      rollback_q     <= rollback_d;
      rollback_pc_q  <= rollback_pc_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  int   errors = 0;
  int   checks = 0;

  reorder_buffer_if bus ();

  reorder_buffer dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // One clock: apply inputs, take the edge, sample 1 ns later, drop the request strobes.
  task automatic step(input logic dv, input logic [1:0] dt, input logic [4:0] drd,
                      input logic cv, input logic [4:0] ct, input logic [31:0] cval,
                      input logic cm, input logic [31:0] cpc);
    bus.disp_valid     = dv;
    bus.disp_type      = dt;
    bus.disp_rd        = drd;
    bus.disp_pc        = 32'h0000_1000;
    bus.cdb_valid      = cv;
    bus.cdb_tag        = ct;
    bus.cdb_value      = cval;
    bus.cdb_mispredict = cm;
    bus.cdb_target_pc  = cpc;
    @(posedge clk);
    #1;
    bus.disp_valid     = 1'b0;
    bus.cdb_valid      = 1'b0;
    bus.cdb_mispredict = 1'b0;
  endtask

  task automatic disp(input logic [1:0] dt, input logic [4:0] drd);
    step(1'b1, dt, drd, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic cdb(input logic [4:0] tag, input logic [31:0] val);
    step(1'b0, 2'd0, 5'd0, 1'b1, tag, val, 1'b0, 32'd0);
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
  endtask

  // Asynchronous pulse placed between clock edges.
  task automatic apply_reset();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    disp(TypeRegWrite, 5'd1);
    disp(TypeRegWrite, 5'd2);
    disp(TypeRegWrite, 5'd3);
    cdb(5'd2, 32'h22);
    cdb(5'd3, 32'h33);
    cdb(5'd0, 32'hBAD0);  // tag 0: no effect
    cdb(5'd9, 32'hBAD9);  // non-busy slot: no effect
    bus.query_tag1 = 5'd2;
    bus.query_tag2 = 5'd1;
    #1;
    checks++; if (bus.query_ready1 !== 1'b1 || bus.query_value1 !== 32'h22) begin
      errors++; $display("FAIL pre_rst_q2: ready=%0b val=%h want 1 00000022",
                         bus.query_ready1, bus.query_value1); end
    checks++; if (bus.query_ready2 !== 1'b0 || bus.query_value2 !== 32'h0) begin
      errors++; $display("FAIL pre_rst_q1: ready=%0b val=%h want 0 0",
                         bus.query_ready2, bus.query_value2); end
    checks++; if (bus.alloc_tag !== 5'd4) begin
      errors++; $display("FAIL pre_rst_alloc: got %0d want 4", bus.alloc_tag); end
    checks++; if (bus.result_valid_to_reg !== 1'b0) begin
      errors++; $display("FAIL head_blocked: result_valid=%0b want 0",
                         bus.result_valid_to_reg); end
    bus.query_tag1 = 5'd9;
    bus.query_tag2 = 5'd0;
    #1;
    checks++; if (bus.query_ready1 !== 1'b0 || bus.query_ready2 !== 1'b0) begin
      errors++; $display("FAIL stray_cdb: ready9=%0b ready0=%0b want 0 0",
                         bus.query_ready1, bus.query_ready2); end
    apply_reset();
    checks++; if (bus.full !== 1'b0) begin
      errors++; $display("FAIL rst_full: got %0b want 0", bus.full); end
    checks++; if (bus.alloc_tag !== 5'd1) begin
      errors++; $display("FAIL rst_alloc_tag: got %0d want 1", bus.alloc_tag); end
    checks++; if ({bus.result_valid_to_reg, bus.store_commit, bus.rollback} !== 3'b000) begin
      errors++; $display("FAIL rst_strobes: got %b want 000",
                         {bus.result_valid_to_reg, bus.store_commit, bus.rollback}); end
    for (int t = 1; t <= 3; t++) begin
      bus.query_tag1 = 5'(t);
      bus.query_tag2 = 5'(t);
      #1;
      checks++; if (bus.query_ready1 !== 1'b0 || bus.query_value1 !== 32'h0 ||
                    bus.query_ready2 !== 1'b0) begin
        errors++; $display("FAIL rst_query_tag%0d: ready=%0b val=%h want 0 0", t,
                           bus.query_ready1, bus.query_value1); end
    end
  endtask

  task automatic test_commit_basic();
    apply_reset();
    disp(TypeRegWrite, 5'd5);
    cdb(5'd1, 32'hDEADBEEF);
    bus.query_tag1 = 5'd1;
    #1;
    checks++; if (bus.query_ready1 !== 1'b1 || bus.query_value1 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL basic_query: ready=%0b val=%h want 1 deadbeef",
                         bus.query_ready1, bus.query_value1); end
    checks++; if (bus.result_valid_to_reg !== 1'b0) begin
      errors++; $display("FAIL basic_early: result_valid=%0b want 0",
                         bus.result_valid_to_reg); end
    idle();
    checks++; if (bus.result_valid_to_reg !== 1'b1 || bus.reg_id_to_reg !== 5'd5 ||
                  bus.alias_to_reg !== 5'd1 || bus.result_to_reg !== 32'hDEADBEEF) begin
      errors++; $display("FAIL basic_commit: v=%0b rd=%0d alias=%0d val=%h want 1 5 1 deadbeef",
                         bus.result_valid_to_reg, bus.reg_id_to_reg, bus.alias_to_reg,
                         bus.result_to_reg); end
    checks++; if (bus.query_ready1 !== 1'b0) begin
      errors++; $display("FAIL basic_query_after: ready=%0b want 0", bus.query_ready1); end
    idle();
    checks++; if (bus.result_valid_to_reg !== 1'b0) begin
      errors++; $display("FAIL basic_pulse: result_valid=%0b want 0", bus.result_valid_to_reg); end
    checks++; if (bus.alloc_tag !== 5'd2) begin
      errors++; $display("FAIL basic_alloc: got %0d want 2", bus.alloc_tag); end
  endtask

  task automatic test_out_of_order();
    logic [31:0] exp_val [3];
    exp_val[0] = 32'h111;
    exp_val[1] = 32'h222;
    exp_val[2] = 32'h333;
    apply_reset();
    disp(TypeRegWrite, 5'd1);
    disp(TypeRegWrite, 5'd2);
    disp(TypeRegWrite, 5'd3);
    cdb(5'd3, 32'h333);
    cdb(5'd2, 32'h222);
    cdb(5'd1, 32'h111);
    checks++; if (bus.result_valid_to_reg !== 1'b0) begin
      errors++; $display("FAIL ooo_early: result_valid=%0b want 0", bus.result_valid_to_reg); end
    for (int k = 0; k < 3; k++) begin
      idle();
      checks++; if (bus.result_valid_to_reg !== 1'b1 || bus.reg_id_to_reg !== 5'(k + 1) ||
                    bus.alias_to_reg !== 5'(k + 1) || bus.result_to_reg !== exp_val[k]) begin
        errors++; $display("FAIL ooo_commit%0d: v=%0b rd=%0d alias=%0d val=%h want 1 %0d %0d %h",
                           k + 1, bus.result_valid_to_reg, bus.reg_id_to_reg,
                           bus.alias_to_reg, bus.result_to_reg, k + 1, k + 1, exp_val[k]); end
    end
    idle();
    checks++; if (bus.result_valid_to_reg !== 1'b0) begin
      errors++; $display("FAIL ooo_drain: result_valid=%0b want 0", bus.result_valid_to_reg); end
  endtask

  task automatic test_full_wrap();
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      checks++; if (bus.full !== 1'b0 || bus.alloc_tag !== 5'(i + 1)) begin
        errors++; $display("FAIL fill_%0d: full=%0b tag=%0d want 0 %0d", i,
                           bus.full, bus.alloc_tag, i + 1); end
      disp(TypeRegWrite, 5'(i + 1));
    end
    checks++; if (bus.full !== 1'b1 || bus.alloc_tag !== 5'd1) begin
      errors++; $display("FAIL full_set: full=%0b tag=%0d want 1 1", bus.full, bus.alloc_tag); end
    disp(TypeRegWrite, 5'd17);  // ignored while full
    step(1'b1, TypeRegWrite, 5'd18, 1'b1, 5'd1, 32'hA1, 1'b0, 32'd0);
    checks++; if (bus.full !== 1'b1) begin
      errors++; $display("FAIL full_hold: full=%0b want 1", bus.full); end
    // Commit edge while full: the same-cycle dispatch must be refused.
    disp(TypeRegWrite, 5'd20);
    checks++; if (bus.result_valid_to_reg !== 1'b1 || bus.alias_to_reg !== 5'd1 ||
                  bus.reg_id_to_reg !== 5'd1 || bus.result_to_reg !== 32'hA1) begin
      errors++; $display("FAIL full_commit: v=%0b alias=%0d rd=%0d val=%h want 1 1 1 a1",
                         bus.result_valid_to_reg, bus.alias_to_reg, bus.reg_id_to_reg,
                         bus.result_to_reg); end
    checks++; if (bus.full !== 1'b0 || bus.alloc_tag !== 5'd1) begin
      errors++; $display("FAIL full_no_alloc: full=%0b tag=%0d want 0 1",
                         bus.full, bus.alloc_tag); end
    disp(TypeRegWrite, 5'd20);
    checks++; if (bus.full !== 1'b1 || bus.alloc_tag !== 5'd2) begin
      errors++; $display("FAIL wrap_refill: full=%0b tag=%0d want 1 2", bus.full, bus.alloc_tag); end
    bus.query_tag1 = 5'd1;
    #1;
    checks++; if (bus.query_ready1 !== 1'b0) begin
      errors++; $display("FAIL wrap_fresh: ready=%0b want 0", bus.query_ready1); end
    cdb(5'd1, 32'hB1);
    checks++; if (bus.query_ready1 !== 1'b1 || bus.query_value1 !== 32'hB1) begin
      errors++; $display("FAIL wrap_cdb: ready=%0b val=%h want 1 b1",
                         bus.query_ready1, bus.query_value1); end
  endtask

  task automatic test_mispredict();
    apply_reset();
    disp(TypeRegWrite, 5'd7);
    disp(TypeBranch, 5'd0);
    disp(TypeRegWrite, 5'd3);
    disp(TypeRegWrite, 5'd4);
    disp(TypeRegWrite, 5'd5);
    cdb(5'd3, 32'h3);
    step(1'b0, 2'd0, 5'd0, 1'b1, 5'd2, 32'd0, 1'b1, 32'h100);
    cdb(5'd1, 32'h77);
    bus.query_tag1 = 5'd3;
    #1;
    checks++; if (bus.query_ready1 !== 1'b1) begin
      errors++; $display("FAIL mp_pre_query: ready=%0b want 1", bus.query_ready1); end
    idle();
    checks++; if (bus.result_valid_to_reg !== 1'b1 || bus.reg_id_to_reg !== 5'd7 ||
                  bus.rollback !== 1'b0) begin
      errors++; $display("FAIL mp_tag1: v=%0b rd=%0d rb=%0b want 1 7 0",
                         bus.result_valid_to_reg, bus.reg_id_to_reg, bus.rollback); end
    idle();
    checks++; if (bus.rollback !== 1'b1 || bus.rollback_pc !== 32'h100) begin
      errors++; $display("FAIL mp_rollback: rb=%0b pc=%h want 1 00000100",
                         bus.rollback, bus.rollback_pc); end
    checks++; if (bus.result_valid_to_reg !== 1'b0 || bus.store_commit !== 1'b0) begin
      errors++; $display("FAIL mp_no_commit: v=%0b st=%0b want 0 0",
                         bus.result_valid_to_reg, bus.store_commit); end
    checks++; if (bus.alloc_tag !== 5'd1 || bus.full !== 1'b0 || bus.query_ready1 !== 1'b0) begin
      errors++; $display("FAIL mp_flushed: tag=%0d full=%0b q3=%0b want 1 0 0",
                         bus.alloc_tag, bus.full, bus.query_ready1); end
    // Inputs presented while rollback is high are dropped.
    step(1'b1, TypeRegWrite, 5'd9, 1'b1, 5'd1, 32'h1, 1'b0, 32'd0);
    checks++; if (bus.rollback !== 1'b0 || bus.alloc_tag !== 5'd1) begin
      errors++; $display("FAIL mp_after: rb=%0b tag=%0d want 0 1", bus.rollback, bus.alloc_tag); end
    disp(TypeRegWrite, 5'd9);
    checks++; if (bus.alloc_tag !== 5'd2) begin
      errors++; $display("FAIL mp_realloc: tag=%0d want 2", bus.alloc_tag); end
  endtask

  task automatic test_store_rd0_rdy();
    int pulses;
    pulses = 0;
    apply_reset();
    disp(TypeRegWrite, 5'd0);
    disp(TypeStore, 5'd0);
    cdb(5'd1, 32'h55);
    cdb(5'd2, 32'h66);  // tag 1 retires at this edge with no strobe
    checks++; if (bus.result_valid_to_reg !== 1'b0 || bus.store_commit !== 1'b0) begin
      errors++; $display("FAIL rd0_silent: v=%0b st=%0b want 0 0",
                         bus.result_valid_to_reg, bus.store_commit); end
    rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      idle();
      checks++; if (bus.store_commit !== 1'b0) begin
        errors++; $display("FAIL rdy_freeze%0d: st=%0b want 0", i, bus.store_commit); end
    end
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      if (bus.store_commit === 1'b1) pulses++;
      if (i == 0) begin
        checks++; if (bus.store_commit !== 1'b1 || bus.result_valid_to_reg !== 1'b0) begin
          errors++; $display("FAIL store_commit: st=%0b v=%0b want 1 0",
                             bus.store_commit, bus.result_valid_to_reg); end
      end
    end
    checks++; if (pulses != 1) begin
      errors++; $display("FAIL store_pulses: got %0d want 1", pulses); end
    checks++; if (bus.alloc_tag !== 5'd3 || bus.full !== 1'b0) begin
      errors++; $display("FAIL store_end: tag=%0d full=%0b want 3 0", bus.alloc_tag, bus.full); end
  endtask

  initial begin
    bus.disp_valid     = 1'b0;
    bus.disp_type      = 2'd0;
    bus.disp_rd        = 5'd0;
    bus.disp_pc        = 32'd0;
    bus.query_tag1     = 5'd0;
    bus.query_tag2     = 5'd0;
    bus.cdb_valid      = 1'b0;
    bus.cdb_tag        = 5'd0;
    bus.cdb_value      = 32'd0;
    bus.cdb_mispredict = 1'b0;
    bus.cdb_target_pc  = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_commit_basic();
    test_out_of_order();
    test_full_wrap();
    test_mispredict();
    test_store_rd0_rdy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement unit of the Tomasulo core.
- Allocates a tag per dispatched instruction and captures results broadcast on the CDB.
- Retires the head entry each cycle it is ready. Drives the register-file commit bus (valid/reg id/alias/value) and the global rollback on branch misprediction.
- Also answers operand-readiness queries from the dispatcher.

Parameters:
- ROB_SIZE, 16, number of entries; must be ≤ 31 so that tags fit ROB_RANGE.
- TAG_W, 5, tag width. Tag = slot index + 1; tag 0 means "no dependency".

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global enable; when low, all state is frozen
- disp_valid  in  1  dispatcher requests allocation this cycle
- disp_type  in  2  0=reg-write, 1=branch, 2=store
- disp_rd  in  5  destination register (ignored for store/branch)
- disp_pc  in  32  PC of the instruction
- alloc_tag  out  TAG_W  tag the next allocation will receive (combinational: tail+1)
- full  out  1  count==ROB_SIZE (combinational)
- query_tag1/query_tag2  in  TAG_W  operand tags to look up
- query_ready1/query_ready2  out  1  entry is busy and its result is ready (combinational)
- query_value1/query_value2  out  32  that entry's value (combinational)
- cdb_valid  in  1  a result broadcast is present
- cdb_tag  in  TAG_W  producing entry
- cdb_value  in  32  result value, or store data
- cdb_mispredict  in  1  branch resolved against the prediction
- cdb_target_pc  in  32  correct PC for a mispredicted branch
- result_valid_to_reg  out  1  commit strobe to the register file
- reg_id_to_reg  out  5  destination register of the committing entry
- alias_to_reg  out  TAG_W  tag of the committing entry
- result_to_reg  out  32  committed value
- store_commit  out  1  head store retired; LSB may perform it
- rollback  out  1  flush strobe to all units
- rollback_pc  out  32  fetch redirect target

Behaviour:
- Storage: per entry busy, ready, type, rd, value, mispredict, target_pc. Pointers head and tail are 0..ROB_SIZE-1 and wrap modulo ROB_SIZE; count is 0..ROB_SIZE.
- Reset (async): head=tail=count=0; all busy=0; all registered outputs = 0.
- rdy low: no state change; all strobes (result_valid_to_reg, store_commit, rollback) are 0 in that cycle's registered update.
- Allocation: on a posedge with disp_valid && !full, write the slot at tail with busy=1 and ready=0, then tail++.
  - disp_valid while full is ignored; no error is raised.
- Writeback: on a posedge with cdb_valid and entry[cdb_tag-1].busy, set ready=1 and store value, mispredict and target_pc.
  - CDB to a non-busy tag or to tag 0 is ignored.
  - The CDB never targets the slot being allocated in the same cycle.
- Commit: at most one per cycle, and only if head.busy && head.ready.
  - Clear busy, head++, and count decrements.
  - Registered outputs are valid the cycle after the edge and pulse for exactly one cycle.
  - reg-write with rd≠0: result_valid_to_reg=1, reg_id_to_reg=rd, alias_to_reg=head+1, result_to_reg=value.
  - reg-write with rd=0: the entry retires silently with no strobe.
  - store: store_commit=1.
  - branch, correctly predicted: retires with no strobe.
  - branch, mispredicted: rollback=1 and rollback_pc=target_pc for one cycle; no register commit. At the same edge, clear all busy bits and set head=tail=count=0. Allocation and CDB inputs at that edge are discarded.
- Input ROB behaviour in the cycle rollback is high: dispatch and CDB inputs are ignored. Downstream units flush on seeing rollback.
- Simultaneous allocation and commit: count stays the same. full is evaluated from the pre-edge count, so a full ROB cannot allocate in the same cycle it commits.
- Query lookup:
  - ready = busy && ready of slot tag-1.
  - Tag 0, or a non-busy slot, returns ready=0 and value=0.
  - The same-cycle CDB value is not forwarded; the dispatcher snoops the CDB itself.
- Latency: allocation to earliest commit is 2 cycles (CDB write, then commit edge).

Decomposition:
- Shared package/include holds ROB_SIZE, ROB_RANGE, REG_RANGE, DATA_RANGE, the entry-type codes and the NO_DEP tag value 0.
- No sub-module. Circular-pointer increment is a local function.

Test Plan:
- Reset mid-run with 3 busy entries: rst pulse → full=0, alloc_tag=1, all strobes 0, and queries for tags 1–3 return ready=0.
- Dispatch reg-write rd=5, CDB tag1 value 0xDEADBEEF → next cycle result_valid_to_reg=1, reg_id=5, alias=1, result=0xDEADBEEF. Then query_tag1 returns ready=0.
- Out-of-order writeback: dispatch tags 1,2,3 (rd 1,2,3); CDB order 3,2,1 → commits arrive in order tags 1,2,3 on consecutive cycles.
- Fill 16 entries → full=1; a 17th disp_valid is ignored. Commit one while dispatching → slot refilled; tail wraps and alloc_tag returns to 1 after tag 16.
- Branch at tag 2 mispredicted (target 0x100) with tags 3–5 busy → after tag 1 commits, rollback=1 and rollback_pc=0x100 for one cycle, no reg strobe, then alloc_tag=1 and count=0.
- rd=0 reg-write and a store → no result_valid_to_reg for rd=0; store_commit pulses exactly once; rdy low for 2 cycles delays the commit without losing it.
